// File: rtl/keypad_matrix_model_if.sv
// Press-command channel of the keypad emulator: valid/ready request plus status.
// master = command source, slave = keypad model.
interface keypad_matrix_model_if;
   logic       req_valid;
   logic [3:0] req_key;
   logic       req_ready;
   logic       busy;
   logic       done;
   logic [3:0] done_key;
   logic       err;

   modport master (
      output req_valid, req_key,
      input  req_ready, busy, done, done_key, err
   );

   modport slave (
      input  req_valid, req_key,
      output req_ready, busy, done, done_key, err
   );
endinterface

// File: rtl/keypad_matrix_model.sv
// 4x3 keypad emulator: closes the addressed switch for a timed press.
// Define KEYPAD_BOUNCE_EN to add LFSR-driven contact chatter at press and release.
module keypad_matrix_model #(
   parameter int HOLD_CYC   = 1000,
   parameter int BOUNCE_CYC = 16,
   parameter int GAP_CYC    = 8,
   parameter int CNT_W      = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] key_col,
   output logic [3:0] key_row,
   keypad_matrix_model_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP
   } state_t;

   // A zero-length setting still occupies one cycle.
   localparam int HN = (HOLD_CYC < 1) ? 1 : HOLD_CYC;
   localparam int GN = (GAP_CYC < 1) ? 1 : GAP_CYC;
   localparam logic [CNT_W-1:0] H_LD = CNT_W'(HN - 1);
   localparam logic [CNT_W-1:0] G_LD = CNT_W'(GN - 1);
`ifdef KEYPAD_BOUNCE_EN
   localparam int BN = (BOUNCE_CYC < 1) ? 1 : BOUNCE_CYC;
   localparam logic [CNT_W-1:0] B_LD = CNT_W'(BN - 1);
`endif

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       key_q;
   logic [1:0]       row_q;
   logic [2:0]       col_q;
   logic             contact;
   logic [1:0]       row_d;
   logic [3:0]       base_d;
   logic [2:0]       col_d;

   assign row_d = (bus.req_key >= 4'd9) ? 2'd3 :
                  (bus.req_key >= 4'd6) ? 2'd2 :
                  (bus.req_key >= 4'd3) ? 2'd1 : 2'd0;
   assign base_d = 4'(row_d) * 4'd3;
   assign col_d = (bus.req_key == base_d)        ? 3'b001 :
                  (bus.req_key == base_d + 4'd1) ? 3'b010 :
                                                   3'b100;

   assign bus.req_ready = (state == IDLE);
   assign bus.busy      = (state != IDLE);

`ifdef KEYPAD_BOUNCE_EN
   logic [7:0] lfsr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr <= 8'hA5;
      end else begin
         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end
   end

   assign contact = (state == HOLD) ||
                    ((state == BOUNCE_IN || state == BOUNCE_OUT) && lfsr[0]);
`else
   assign contact = (state == HOLD);
`endif

   always_comb begin
      key_row = '0;
      key_row[row_q] = contact & |(key_col & col_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         key_q        <= '0;
         row_q        <= '0;
         col_q        <= '0;
         bus.done     <= 1'b0;
         bus.done_key <= '0;
         bus.err      <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         bus.err  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  if (bus.req_key < 4'd12) begin
                     key_q <= bus.req_key;
                     row_q <= row_d;
                     col_q <= col_d;
`ifdef KEYPAD_BOUNCE_EN
                     state <= BOUNCE_IN;
                     cnt   <= B_LD;
`else
                     state <= HOLD;
                     cnt   <= H_LD;
`endif
                  end else begin
                     bus.err <= 1'b1;
                  end
               end
            end
            BOUNCE_IN: begin
               if (cnt == '0) begin
                  state <= HOLD;
                  cnt   <= H_LD;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            HOLD: begin
               if (cnt == '0) begin
`ifdef KEYPAD_BOUNCE_EN
                  state <= BOUNCE_OUT;
                  cnt   <= B_LD;
`else
                  state        <= GAP;
                  cnt          <= G_LD;
                  bus.done     <= 1'b1;
                  bus.done_key <= key_q;
`endif
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            BOUNCE_OUT: begin
               if (cnt == '0) begin
                  state        <= GAP;
                  cnt          <= G_LD;
                  bus.done     <= 1'b1;
                  bus.done_key <= key_q;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            GAP: begin
               if (cnt == '0) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_matrix_model.sv
// Randomized bench for keypad_matrix_model against a press-timeline model.
// Build with KEYPAD_BOUNCE_EN defined to exercise the bounce windows.
module tb_keypad_matrix_model;

   localparam int H  = 4;
   localparam int G  = 2;
   localparam int B  = 16;
`ifdef KEYPAD_BOUNCE_EN
   localparam int BI = B;
   localparam int TOT_LIT = 38;
`else
   localparam int BI = 0;
   localparam int TOT_LIT = 6;
`endif
   localparam int TOTAL = BI + H + BI + G;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] key_col = 3'b000;
   logic [3:0] key_row;

   keypad_matrix_model_if bus ();

   keypad_matrix_model #(
      .HOLD_CYC   (H),
      .BOUNCE_CYC (B),
      .GAP_CYC    (G),
      .CNT_W      (16)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .key_col (key_col),
      .key_row (key_row),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;
   bit chk_on  = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
   endtask

   // Column drive: 0 fixed, 1 rotating one-hot, 2 random (incl. 0 and multi-hot).
   int         col_mode  = 0;
   logic [2:0] fixed_col = 3'b000;
   int         rot = 0;

   always @(posedge clk) begin
      #1;
      rot = (rot + 1) % 3;
      case (col_mode)
         1: key_col = 3'(1 << rot);
         2: key_col = 3'($urandom_range(0, 7));
         default: key_col = fixed_col;
      endcase
   end

   // Model: e = cycles since the accepting edge, 0 when idle.
   int         e;
   logic [3:0] mk;
   logic       m_err;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         e     <= 0;
         mk    <= 4'd0;
         m_err <= 1'b0;
      end else begin
         m_err <= 1'b0;
         if (e == 0) begin
            if (bus.req_valid) begin
               if (bus.req_key < 4'd12) begin
                  e  <= 1;
                  mk <= bus.req_key;
               end else begin
                  m_err <= 1'b1;
               end
            end
         end else begin
            e <= (e == TOTAL) ? 0 : e + 1;
         end
      end
   end

   always @(negedge clk) begin : cmp
      logic [3:0] full;
      logic       hold;
      logic       bnc;
      logic       dn;
      if (!rst && chk_on) begin
         full = key_col[mk % 3] ? 4'(1 << (mk / 3)) : 4'b0000;
         hold = (e >= BI + 1) && (e <= BI + H);
         bnc  = (e >= 1 && e <= BI) || (e > BI + H && e <= 2 * BI + H);
         dn   = (e == 2 * BI + H + 1);
         chk("busy", bus.busy, e != 0);
         chk("req_ready", bus.req_ready, e == 0);
         chk("done", bus.done, dn);
         chk("err", bus.err, m_err);
         if (dn) chk("done_key", bus.done_key, mk);
         if (bnc) chk("row_bounce", key_row & ~full, 4'b0);
         else chk("key_row", key_row, hold ? full : 4'b0);
      end
   end

   task automatic press(input logic [3:0] k);
      int n;
      n = 0;
      while (!bus.req_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) chk("ready_timeout", 0, 1);
      bus.req_valid = 1'b1;
      bus.req_key   = k;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
   endtask

   task automatic wait_done(output logic [3:0] dk);
      int n;
      n = 0;
      dk = 4'hF;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.done && n < 500);
      if (!bus.done) chk("done_timeout", 0, 1);
      else dk = bus.done_key;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.busy && n < 500);
      if (bus.busy) chk("idle_timeout", 0, 1);
   endtask

   initial begin
      logic [3:0] dk;
      int nb, done_at, ready_at, ec, bc, rc, dc;
      int tin, tout, hon;
      logic prv;

      bus.req_valid = 1'b0;
      bus.req_key   = 4'd0;

      repeat (3) @(negedge clk);
      chk("rst_row", key_row, 4'b0);
      chk("rst_ready", bus.req_ready, 1'b1);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_done_key", bus.done_key, 4'd0);
      chk("rst_err", bus.err, 1'b0);
      #2 rst = 1'b0;
      chk_on = 1'b1;

      // Key 5 = row 1, col 2.
      fixed_col = 3'b100;
      @(negedge clk);
      press(4'd5);
      nb = 0; done_at = 0; ready_at = 0;
      for (int c = 1; c <= TOTAL + 3; c++) begin
         @(negedge clk);
         if (bus.busy) nb++;
         if (bus.done) begin
            done_at = c;
            chk("t2_done_key", bus.done_key, 4'd5);
         end
         if (bus.req_ready && ready_at == 0) ready_at = c;
         if (c == BI + 1) begin
            chk("t2_row_col2", key_row, 4'b0010);
            fixed_col = 3'b001;
         end
         if (c == BI + 2) begin
            chk("t2_row_col0", key_row, 4'b0000);
            fixed_col = 3'b100;
         end
      end
      chk("t2_busy_len", nb, TOT_LIT);
      chk("t2_done_lead", ready_at - done_at, 2);

      col_mode = 1;
      for (int k = 0; k < 12; k++) begin
         press(4'(k));
         wait_done(dk);
         chk("sweep_done_key", dk, k);
         wait_idle();
      end

      col_mode = 0;
      fixed_col = 3'b111;
      press(4'd13);
      ec = 0; bc = 0; rc = 0; dc = 0;
      repeat (5) begin
         @(negedge clk);
         ec += int'(bus.err);
         bc += int'(bus.busy);
         dc += int'(bus.done);
         rc += int'(key_row != 4'b0);
      end
      chk("t4_err_pulses", ec, 1);
      chk("t4_busy", bc, 0);
      chk("t4_row", rc, 0);
      chk("t4_done", dc, 0);

      press(4'd2);
      bus.req_valid = 1'b1;
      bus.req_key   = 4'd7;
      wait_done(dk);
      chk("t5_first_key", dk, 4'd2);
      nb = 0;
      while (!bus.req_ready && nb < 200) begin
         @(negedge clk);
         nb++;
      end
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      wait_done(dk);
      chk("t5_second_key", dk, 4'd7);
      wait_idle();

`ifdef KEYPAD_BOUNCE_EN
      fixed_col = 3'b111;
      @(negedge clk);
      press(4'd0);
      tin = 0; tout = 0; hon = 0; prv = 1'b0;
      for (int c = 1; c <= TOTAL; c++) begin
         @(negedge clk);
         if (c >= 2 && c <= BI && key_row[0] != prv) tin++;
         if (c >= BI + H + 2 && c <= 2 * BI + H && key_row[0] != prv) tout++;
         if (c > BI && c <= BI + H) hon += int'(key_row[0]);
         prv = key_row[0];
      end
      chk("t6_toggle_in", tin > 0, 1'b1);
      chk("t6_toggle_out", tout > 0, 1'b1);
      chk("t6_solid", hon, H);
      wait_idle();
`else
      tin = 0; tout = 0; hon = 0; prv = 1'b0;
`endif

      col_mode = 2;
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         press(4'($urandom_range(0, 15)));
      end
      wait_idle();

      col_mode = 0;
      fixed_col = 3'b111;
      @(negedge clk);
      press(4'd4);
      repeat (BI + 2) @(negedge clk);
      chk("t1_row_before", key_row, 4'b0010);
      #2 rst = 1'b1;
      #1;
      chk("t1_row_in_rst", key_row, 4'b0);
      chk("t1_busy_in_rst", bus.busy, 1'b0);
      @(negedge clk);
      chk("t1_row_rst_held", key_row, 4'b0);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("t1_ready_after", bus.req_ready, 1'b1);
      chk("t1_busy_after", bus.busy, 1'b0);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
